// File: rtl/uart_pkg.sv
// Shared types for the UART receive path.
//   parity_e   : decoded parity setting (PAR_NONE / PAR_EVEN / PAR_ODD)
//   rx_state_e : receive FSM states, also exported on the engine debug port
//   rx_word_t  : one received character as stored in the RX FIFO
//   RX_WORD_W  : packed width of rx_word_t
package uart_pkg;

  localparam int RX_WORD_W = 11;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } rx_state_e;

  typedef struct packed {
    logic       brk;
    logic       frame_err;
    logic       parity_err;
    logic [7:0] data;
  } rx_word_t;

  // The 2-bit parity field has one spare code; it behaves as "no parity".
  function automatic parity_e decode_parity(input logic [1:0] mode);
    case (mode)
      2'd1:    return PAR_EVEN;
      2'd2:    return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_engine_if.sv
// Received-character stream between the RX engine and its consumer
// (register read path or DMA).
//   m_valid : head entry present
//   m_data  : head entry {brk, frame_err, parity_err, data[7:0]}
//   m_ready : consumer takes the head entry
//
// Handshake: a transfer happens in every cycle where m_valid and m_ready are
// both high at the rising clock edge. The producer holds m_data stable while
// m_valid is high and no transfer has happened; the producer never waits for
// m_ready before raising m_valid, and m_ready may be high while m_valid is low
// (no transfer occurs then).
interface uart_rx_engine_if;
  import uart_pkg::*;

  logic                 m_valid;
  logic [RX_WORD_W-1:0] m_data;
  logic                 m_ready;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO shared by the UART RX and TX paths.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : empties the FIFO; wins over push and pop in the same cycle
//   push       : write push_data (accepted if not full, or full with a pop)
//   pop        : remove the head entry (ignored when empty)
//   rd_data    : head entry, read combinationally from the registered memory
//   level      : current occupancy; level_next is the value it takes next edge
//   full/empty : occupancy flags
//   pop_acc    : a pop is really taking place this cycle
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] level,
  output logic [$clog2(DEPTH):0] level_next,
  output logic                   full,
  output logic                   empty,
  output logic                   pop_acc
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_acc;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign pop_acc = pop && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign push_acc = push && (!full || pop_acc);
  assign rd_data  = mem[rd_ptr];

  always_comb begin
    level_next = level;
    if (flush) begin
      level_next = '0;
    end else begin
      case ({push_acc, pop_acc})
        2'b10:   level_next = level + LW'(1);
        2'b01:   level_next = level - LW'(1);
        default: level_next = level;
      endcase
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop_acc)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_rx_engine.sv
// Oversampling UART receiver with RX FIFO, threshold flag, idle timeout and
// sticky overrun.
//   clk, rst     : clock, synchronous active-high reset
//   rx_pin       : asynchronous serial input, idles high
//   enable       : receiver enable; dropping it abandons a frame in progress
//   baud_div     : clk cycles per oversample tick (0 behaves as 1)
//   data_bits    : 5 + value data bits
//   parity_mode  : 0 none, 1 even, 2 odd, 3 none
//   two_stop     : check a second stop bit
//   rx_thresh    : FIFO level threshold for thresh_hit (0 disables)
//   timeout_bits : idle timeout in bit times (0 disables)
//   flush        : empty the FIFO, clear rx_timeout and overrun
//   m_if         : received-word stream (master side)
//   fifo_level   : FIFO occupancy
//   thresh_hit   : fifo_level >= rx_thresh, rx_thresh non-zero (registered)
//   rx_timeout   : FIFO has data and the line has been idle long enough
//   overrun      : a completed frame found the FIFO full (sticky)
//   busy         : receive FSM not idle
//   dbg_state    : receive FSM state
module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int TMO_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_pin,
  input  logic                        enable,
  input  logic [DIV_WIDTH-1:0]        baud_div,
  input  logic [1:0]                  data_bits,
  input  logic [1:0]                  parity_mode,
  input  logic                        two_stop,
  input  logic [$clog2(FIFO_DEPTH):0] rx_thresh,
  input  logic [TMO_WIDTH-1:0]        timeout_bits,
  input  logic                        flush,
  uart_rx_engine_if.master            m_if,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        thresh_hit,
  output logic                        rx_timeout,
  output logic                        overrun,
  output logic                        busy,
  output rx_state_e                   dbg_state
);

  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int LW  = $clog2(FIFO_DEPTH) + 1;
  // Start bit is confirmed half a bit after the edge; later bits one full
  // bit apart, which keeps every sample at mid-bit.
  localparam logic [SCW-1:0] SC_MID  = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);

  // ---------------------------------------------------------------------
  // Input synchroniser and edge detect
  // ---------------------------------------------------------------------
  logic sync1, rxs, rxs_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= rx_pin;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  // ---------------------------------------------------------------------
  // Oversample tick generator
  // ---------------------------------------------------------------------
  logic [DIV_WIDTH-1:0] div_reload, tick_cnt;
  logic                 tick;

  assign div_reload = (baud_div == '0) ? '0 : baud_div - DIV_WIDTH'(1);
  assign tick       = enable && (tick_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      tick_cnt <= div_reload;
    end else if (tick_cnt == '0) begin
      tick_cnt <= div_reload;
    end else begin
      tick_cnt <= tick_cnt - DIV_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------
  rx_state_e      state, state_n;
  logic [SCW-1:0] sc, sc_n, sc_adv;
  logic [2:0]     bit_idx, bit_idx_n, last_idx;
  logic [7:0]     shreg, shreg_n;
  logic           par_err_q, par_err_n;
  logic           frm_err_q, frm_err_n;
  logic           frm_final;
  logic           bit_mid;
  logic           par_en;
  logic           exp_par;
  parity_e        par_sel;
  logic           push;
  rx_word_t       push_word;

  assign par_sel  = decode_parity(parity_mode);
  assign par_en   = (par_sel != PAR_NONE);
  // Unused high bits of shreg stay 0, so a full-byte XOR is the data XOR.
  assign exp_par  = (par_sel == PAR_ODD) ? ~(^shreg) : ^shreg;
  assign last_idx = 3'(data_bits) + 3'd4;
  assign bit_mid  = tick && (sc == SC_LAST);
  assign sc_adv   = tick ? (bit_mid ? '0 : sc + SCW'(1)) : sc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      sc        <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      state     <= state_n;
      sc        <= sc_n;
      bit_idx   <= bit_idx_n;
      shreg     <= shreg_n;
      par_err_q <= par_err_n;
      frm_err_q <= frm_err_n;
    end
  end

  always_comb begin
    state_n   = state;
    sc_n      = sc;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    par_err_n = par_err_q;
    frm_err_n = frm_err_q;
    frm_final = frm_err_q;
    push      = 1'b0;
    if (!enable) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rxs_d && !rxs) begin
            state_n   = ST_START;
            sc_n      = '0;
            bit_idx_n = '0;
            shreg_n   = '0;
            par_err_n = 1'b0;
            frm_err_n = 1'b0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (sc == SC_MID) begin
              sc_n    = '0;
              state_n = rxs ? ST_IDLE : ST_DATA;
            end else begin
              sc_n = sc + SCW'(1);
            end
          end
        end
        ST_DATA: begin
          sc_n = sc_adv;
          if (bit_mid) begin
            shreg_n[bit_idx] = rxs;
            bit_idx_n        = bit_idx + 3'd1;
            if (bit_idx == last_idx) state_n = par_en ? ST_PARITY : ST_STOP1;
          end
        end
        ST_PARITY: begin
          sc_n = sc_adv;
          if (bit_mid) begin
            par_err_n = (rxs != exp_par);
            state_n   = ST_STOP1;
          end
        end
        ST_STOP1: begin
          sc_n = sc_adv;
          if (bit_mid) begin
            frm_err_n = !rxs;
            if (two_stop) begin
              state_n = ST_STOP2;
            end else begin
              frm_final = !rxs;
              push      = 1'b1;
              state_n   = ST_IDLE;
            end
          end
        end
        ST_STOP2: begin
          sc_n = sc_adv;
          if (bit_mid) begin
            frm_final = frm_err_q | !rxs;
            frm_err_n = frm_final;
            push      = 1'b1;
            state_n   = ST_IDLE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
    push_word.data       = shreg;
    push_word.parity_err = par_err_q;
    push_word.frame_err  = frm_final;
    push_word.brk        = frm_final && (shreg == 8'd0);
  end

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  // ---------------------------------------------------------------------
  // RX FIFO and stream output
  // ---------------------------------------------------------------------
  logic [RX_WORD_W-1:0] fifo_rd;
  logic [LW-1:0]        level_next;
  logic                 fifo_full, fifo_empty, pop_acc, push_drop;

  uart_sync_fifo #(
    .WIDTH (RX_WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push       (push),
    .push_data  (push_word),
    .pop        (m_if.m_ready),
    .rd_data    (fifo_rd),
    .level      (fifo_level),
    .level_next (level_next),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .pop_acc    (pop_acc)
  );

  // The memory is not reset; hide its contents while nothing is queued.
  assign m_if.m_valid = !fifo_empty;
  assign m_if.m_data  = fifo_empty ? '0 : fifo_rd;
  assign push_drop    = push && fifo_full && !pop_acc;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      overrun <= 1'b0;
    end else if (push_drop) begin
      overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      thresh_hit <= 1'b0;
    end else begin
      thresh_hit <= (rx_thresh != '0) && (level_next >= rx_thresh);
    end
  end

  // ---------------------------------------------------------------------
  // Idle timeout: counts whole bit times while idle with data waiting
  // ---------------------------------------------------------------------
  logic [SCW-1:0]       bt_sc;
  logic [TMO_WIDTH-1:0] tmo_cnt;
  logic                 tmo_clr;

  assign tmo_clr = push || pop_acc || flush || (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst || tmo_clr) begin
      bt_sc   <= '0;
      tmo_cnt <= '0;
    end else if (!fifo_empty && tick) begin
      if (bt_sc == SC_LAST) begin
        bt_sc <= '0;
        if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + TMO_WIDTH'(1);
      end else begin
        bt_sc <= bt_sc + SCW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || push || pop_acc || flush) begin
      rx_timeout <= 1'b0;
    end else if ((timeout_bits != '0) && (tmo_cnt >= timeout_bits)) begin
      rx_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine: serial driver tasks, a character-level
// model queue, a per-cycle compare process and a final report.
module tb_uart_rx_engine;
  import uart_pkg::*;

  localparam int FD = 16;
  localparam int OS = 16;
  localparam int DW = 16;
  localparam int TW = 8;
  localparam int LW = $clog2(FD) + 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_pin = 1'b1;
  logic          enable = 1'b0;
  logic [DW-1:0] baud_div = 16'd4;
  logic [1:0]    data_bits = 2'd3;
  logic [1:0]    parity_mode = 2'd0;
  logic          two_stop = 1'b0;
  logic [LW-1:0] rx_thresh = '0;
  logic [TW-1:0] timeout_bits = '0;
  logic          flush = 1'b0;
  logic [LW-1:0] fifo_level;
  logic          thresh_hit, rx_timeout, overrun, busy;
  rx_state_e     dbg_state;

  uart_rx_engine_if m_if ();

  always #5 clk = ~clk;

  uart_rx_engine #(
    .FIFO_DEPTH (FD),
    .OVERSAMPLE (OS),
    .DIV_WIDTH  (DW),
    .TMO_WIDTH  (TW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_pin       (rx_pin),
    .enable       (enable),
    .baud_div     (baud_div),
    .data_bits    (data_bits),
    .parity_mode  (parity_mode),
    .two_stop     (two_stop),
    .rx_thresh    (rx_thresh),
    .timeout_bits (timeout_bits),
    .flush        (flush),
    .m_if         (m_if),
    .fifo_level   (fifo_level),
    .thresh_hit   (thresh_hit),
    .rx_timeout   (rx_timeout),
    .overrun      (overrun),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int                   vectors = 0;
  int                   miscompares = 0;
  logic [RX_WORD_W-1:0] exp_q[$];
  logic                 exp_ovr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  // Character-level model: what a frame must turn into.
  function automatic logic [RX_WORD_W-1:0] model_word(input logic [7:0] d, input int nbits,
                                                       input logic [1:0] pmode, input bit bad_par,
                                                       input bit stop_ok);
    logic [7:0] dd;
    logic       perr, ferr;
    dd   = d & 8'((1 << nbits) - 1);
    perr = bad_par && (pmode == 2'd1 || pmode == 2'd2);
    ferr = !stop_ok;
    return {ferr && (dd == 8'd0), ferr, perr, dd};
  endfunction

  // FIFO occupancy in the model is the queue size (no draining while sending).
  task automatic model_push(input logic [RX_WORD_W-1:0] w);
    if (exp_q.size() >= FD) exp_ovr = 1'b1;
    else exp_q.push_back(w);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("valid_vs_level", 32'(m_if.m_valid), 32'(fifo_level != '0));
      check("thresh_rule", 32'(thresh_hit), 32'((rx_thresh != '0) && (fifo_level >= rx_thresh)));
      if (m_if.m_valid && m_if.m_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL pop_unexpected: got 0x%0h, expected no entry", m_if.m_data);
        end else begin
          check("pop_data", 32'(m_if.m_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // First-entry latency monitor.
  int   start_cyc = 0;
  int   rise_cyc = 0;
  logic valid_prev = 1'b0;
  always @(negedge clk) begin
    if (m_if.m_valid && !valid_prev) rise_cyc <= cyc;
    valid_prev <= m_if.m_valid;
  end

  // ---------------- driver tasks ----------------
  function automatic int bit_clks();
    return ((baud_div == '0) ? 1 : int'(baud_div)) * OS;
  endfunction

  task automatic drive_bit(input logic b);
    rx_pin = b;
    repeat (bit_clks()) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit flip_par);
    int         nb;
    logic [7:0] mask;
    logic       p;
    nb   = 5 + int'(data_bits);
    mask = 8'((1 << nb) - 1);
    model_push(model_word(d, nb, parity_mode, flip_par, 1'b1));
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < nb; i++) drive_bit(d[i]);
    if (parity_mode == 2'd1 || parity_mode == 2'd2) begin
      p = ^(d & mask);
      if (parity_mode == 2'd2) p = ~p;
      drive_bit(p ^ flip_par);
    end
    drive_bit(1'b1);
    if (two_stop) drive_bit(1'b1);
  endtask

  task automatic pop_one();
    m_if.m_ready = 1'b1;
    idle(1);
    m_if.m_ready = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    m_if.m_ready = 1'b1;
    while (m_if.m_valid && n < 64) begin
      idle(1);
      n++;
    end
    m_if.m_ready = 1'b0;
    check("drain_in_bound", 32'(n < 64), 32'd1);
    check("drain_level", 32'(fifo_level), 32'd0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    exp_q.delete();
    exp_ovr = 1'b0;
  endtask

  task automatic wait_timeout(output int n);
    n = 0;
    while (!rx_timeout && n < 600) begin
      idle(1);
      n++;
    end
  endtask

  // Mixed frame formats: data, data_bits, parity_mode, two_stop, bad parity
  logic [7:0] t_d  [4] = '{8'hFF, 8'hC3, 8'h5A, 8'h00};
  logic [1:0] t_db [4] = '{2'd0, 2'd1, 2'd3, 2'd3};
  logic [1:0] t_pm [4] = '{2'd2, 2'd3, 2'd2, 2'd0};
  logic       t_ts [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic       t_fp [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int n;
    m_if.m_ready = 1'b0;
    idle(3);
    check("rst_valid", 32'(m_if.m_valid), 32'd0);
    check("rst_data", 32'(m_if.m_data), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_thresh", 32'(thresh_hit), 32'd0);
    check("rst_timeout", 32'(rx_timeout), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    enable = 1'b1;
    idle(4);

    // 8N1 0xA5 at baud_div 4
    send_frame(8'hA5, 1'b0);
    idle(4);
    check("a5_head", 32'(m_if.m_data), 32'h0A5);
    check("a5_level", 32'(fifo_level), 32'd1);
    lat = rise_cyc - start_cyc;
    check("a5_latency_window", 32'(lat >= 9 * 64 && lat <= 10 * 64 + 16), 32'd1);
    check("a5_busy", 32'(busy), 32'd0);
    drain();

    // 7E2: good parity then flipped parity
    data_bits = 2'd2; parity_mode = 2'd1; two_stop = 1'b1;
    send_frame(8'h35, 1'b0);
    send_frame(8'h35, 1'b1);
    idle(4);
    check("e2_head0", 32'(m_if.m_data), 32'h035);
    check("e2_level", 32'(fifo_level), 32'd2);
    pop_one();
    check("e2_head1", 32'(m_if.m_data), 32'h135);
    drain();

    // Mixed formats through the model only
    for (int i = 0; i < 4; i++) begin
      data_bits = t_db[i]; parity_mode = t_pm[i]; two_stop = t_ts[i];
      send_frame(t_d[i], t_fp[i]);
    end
    idle(4);
    check("mix_level", 32'(fifo_level), 32'd4);
    drain();

    // 3-tick low glitch: false start
    data_bits = 2'd3; parity_mode = 2'd0; two_stop = 1'b0;
    rx_pin = 1'b0;
    idle(12);
    check("glitch_busy", 32'(busy), 32'd1);
    rx_pin = 1'b1;
    idle(40);
    check("glitch_idle", 32'(busy), 32'd0);
    check("glitch_state", 32'(dbg_state), 32'(ST_IDLE));
    check("glitch_level", 32'(fifo_level), 32'd0);

    // enable dropped mid-frame
    rx_pin = 1'b0;
    idle(2 * bit_clks());
    check("en_mid_busy", 32'(busy), 32'd1);
    enable = 1'b0;
    idle(1);
    check("en_drop_idle", 32'(busy), 32'd0);
    rx_pin = 1'b1;
    idle(4);
    enable = 1'b1;
    idle(2 * bit_clks());
    check("en_drop_level", 32'(fifo_level), 32'd0);

    // Break: 12 bit times low, then a normal frame
    model_push(model_word(8'h00, 8, 2'd0, 1'b0, 1'b0));
    repeat (12) drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("brk_head", 32'(m_if.m_data), 32'h600);
    check("brk_busy", 32'(busy), 32'd0);
    send_frame(8'h3C, 1'b0);
    idle(4);
    check("brk_next_level", 32'(fifo_level), 32'd2);
    drain();

    // Fill: 17 bytes, baud_div 0 behaves as 1
    baud_div = '0; rx_thresh = LW'(16); timeout_bits = '0;
    for (int i = 0; i < 17; i++) send_frame(8'(i * 29 + 3), 1'b0);
    idle(4);
    check("fill_level", 32'(fifo_level), 32'd16);
    check("fill_overrun", 32'(overrun), 32'(exp_ovr));
    check("fill_thresh", 32'(thresh_hit), 32'd1);
    check("fill_head", 32'(m_if.m_data), 32'h003);
    idle(20 * bit_clks());
    check("tmo_disabled", 32'(rx_timeout), 32'd0);
    drain();
    check("overrun_sticky", 32'(overrun), 32'd1);
    do_flush();
    check("flush_overrun", 32'(overrun), 32'd0);
    check("flush_level", 32'(fifo_level), 32'd0);

    // Threshold and idle timeout
    baud_div = 16'd4; rx_thresh = LW'(3); timeout_bits = TW'(4);
    send_frame(8'h11, 1'b0);
    send_frame(8'h22, 1'b0);
    check("tmo_thresh_low", 32'(thresh_hit), 32'd0);
    check("tmo_not_yet", 32'(rx_timeout), 32'd0);
    wait_timeout(n);
    check("tmo_rise_window", 32'(n >= 200 && n <= 260), 32'd1);
    check("tmo_set", 32'(rx_timeout), 32'd1);
    pop_one();
    check("tmo_pop_clear", 32'(rx_timeout), 32'd0);
    check("tmo_pop_level", 32'(fifo_level), 32'd1);
    send_frame(8'h33, 1'b0);
    send_frame(8'h44, 1'b0);
    idle(4);
    check("thresh_at_3", 32'(thresh_hit), 32'd1);
    wait_timeout(n);
    check("tmo_set_again", 32'(rx_timeout), 32'd1);
    do_flush();
    check("flush_timeout", 32'(rx_timeout), 32'd0);
    check("flush_valid", 32'(m_if.m_valid), 32'd0);
    idle(2);
    check("flush_thresh", 32'(thresh_hit), 32'd0);

    check("queue_consumed", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    miscompares++;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_engine.md
Name: uart_rx_engine

Overview:
- Parametrised, oversampling UART receive engine with a built-in RX FIFO, a threshold flag, an idle-timeout flag and sticky error reporting.
- Runtime-configurable frame format: 5–8 data bits, none/even/odd parity, 1 or 2 stop bits.
- Sits between the uart_rx_pin pad and the register/DMA layer of the UART wrapper.
- Output is a valid/ready byte stream that can be drained by either Wishbone reads or the DMA path.

Parameters:
- FIFO_DEPTH, 16, RX FIFO entries; power of two, at least 2.
- OVERSAMPLE, 16, baud ticks per bit; even, at least 4.
- DIV_WIDTH, 16, width of the baud divisor.
- TMO_WIDTH, 8, width of the idle-timeout setting, in bit times.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx_pin  in  1  asynchronous serial input; idles high
- enable  in  1  receiver enable
- baud_div  in  DIV_WIDTH  clk cycles per oversample tick; value 0 is treated as 1
- data_bits  in  2  data bits = 5 + value
- parity_mode  in  2  0 none, 1 even, 2 odd, 3 treated as none
- two_stop  in  1  1 = check two stop bits
- rx_thresh  in  $clog2(FIFO_DEPTH)+1  FIFO level threshold
- timeout_bits  in  TMO_WIDTH  idle timeout in bit times; 0 disables the timeout
- flush  in  1  empty the FIFO, clear timeout and overrun
- m_valid  out  1  FIFO head is valid
- m_data  out  11  {brk, frame_err, parity_err, data[7:0]}; unused high data bits are 0
- m_ready  in  1  consumer accepts the head entry
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- thresh_hit  out  1  fifo_level >= rx_thresh and rx_thresh != 0
- rx_timeout  out  1  idle timeout flag
- overrun  out  1  sticky overrun flag
- busy  out  1  FSM not in IDLE

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset values: all outputs 0; FIFO empty; FSM in IDLE; synchroniser flops at 1.
- Input synchronisation: rx_pin passes through a 2-flop synchroniser to give rxs. rxs_d is rxs delayed by one cycle.
- Tick generator: counter reloads with max(baud_div,1)-1 and emits a one-cycle tick when it reaches 0. It free-runs while enable=1 and is held at reload while enable=0.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2. A per-state tick counter sc counts 0..OVERSAMPLE-1.
- IDLE: a falling edge (rxs_d=1, rxs=0) with enable=1 moves to START and sets sc=0.
- START: at sc = OVERSAMPLE/2-1 sample rxs.
  - rxs=1: false start, return to IDLE.
  - rxs=0: go to DATA and restart sc.
  - From here on every sample is taken at mid-bit, i.e. every OVERSAMPLE ticks.
- DATA: shift bits in LSB-first. After 5+data_bits samples, go to PARITY if parity_mode is 1 or 2, otherwise to STOP1.
- PARITY: parity_err = sampled bit differs from expected.
  - Even: expected = XOR of data bits.
  - Odd: expected = inverted XOR of data bits.
- STOP1: sample the stop bit; frame_err = (sample == 0).
  - If two_stop=1 go to STOP2, else push the frame and go to IDLE.
- STOP2: sample; frame_err |= (sample == 0). Then push the frame and go to IDLE.
- Frame completion is at mid-stop-bit. This permits resynchronisation on the very next falling edge.
- Break: brk=1 when all data bits are 0 and frame_err=1. After a framing error, IDLE needs rxs to return high before a new falling edge can start a frame; edge detection provides this inherently.
- enable=0 mid-frame: FSM returns to IDLE next cycle and the partial frame is discarded. The FIFO is unaffected.
- FIFO behaviour:
  - First-word-fall-through: m_valid = !empty, and m_data = head entry combinationally from a registered memory and pointer.
  - A pushed entry appears on m_valid in the cycle after the push cycle.
  - A pop occurs when m_valid && m_ready.
  - A push is accepted when not full, or when full with a pop in the same cycle.
  - Otherwise the push is dropped and overrun is set. overrun stays set until flush or rst.
  - Pointers wrap modulo FIFO_DEPTH. fifo_level stays exact on simultaneous push and pop.
  - flush has priority over push and pop in the same cycle: level becomes 0, overrun and rx_timeout become 0, and the FSM is unaffected.
- Idle timeout:
  - A bit-time counter advances every OVERSAMPLE ticks while FSM is IDLE and the FIFO is non-empty.
  - The counter clears on push, pop, flush, or any non-IDLE state.
  - When it reaches timeout_bits (non-zero), rx_timeout is set. It stays set until the next pop, push or flush.
- thresh_hit is registered, updated each cycle from the next fifo_level.

Decomposition:
- uart_pkg holds:
  - parity_e (PAR_NONE, PAR_EVEN, PAR_ODD);
  - rx_state_e;
  - rx_word_t struct {brk, frame_err, parity_err, data[7:0]};
  - localparam RX_WORD_W = 11.
- Sub-module uart_sync_fifo (parameters WIDTH, DEPTH; push/pop/flush/level/full/empty) is natural and reused for TX.

Test Plan:
- baud_div=4, OVERSAMPLE=16, 8N1, send 0xA5 -> one entry m_data=0x0A5, no error bits; m_valid rises about 10 bit times after the start edge.
- 7E2, send 0x35 with correct parity, then 0x35 with flipped parity bit -> entries 0x035 and 0x135 (parity_err).
- Low glitch of 3 ticks on an idle line -> no entry, busy returns to 0, FSM in IDLE.
- Line held low for 12 bit times (8N1) -> entry 0x600 (brk and frame_err); next frame is received correctly after the line returns high.
- FIFO_DEPTH=16, m_ready=0, send 17 bytes -> fifo_level=16, overrun=1, first 16 bytes intact; then flush -> level 0, overrun 0.
- rx_thresh=3, timeout_bits=4, send 2 bytes and go idle -> thresh_hit=0; rx_timeout=1 after 4 idle bit times; one pop -> rx_timeout=0.
